axi_ar_rr_scheduler: RTL and testbench
======================================

AXI_AR_RR_SCHEDULER -- requirements
Module: axi_ar_rr_scheduler

Interface
REQ-001 SHALL have parameter N_TARG_PORT, default 7, number of AR requesters.
REQ-002 SHALL have parameter LOG_N_TARG, default $clog2(N_TARG_PORT), requester index width.
REQ-003 SHALL have parameter MAX_OUTST, default 8, per-requester outstanding-read limit (>=1).
REQ-004 SHALL have parameter CNT_W, default $clog2(MAX_OUTST+1), counter width.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_i, input, N_TARG_PORT, per-requester arvalid.
REQ-008 SHALL have port gnt_o, output, N_TARG_PORT, one-hot arready to requesters.
REQ-009 SHALL have port sel_o, output, LOG_N_TARG, index of requester driving the AR mux.
REQ-010 SHALL have port valid_o, output, 1, arvalid to the downstream slave port.
REQ-011 SHALL have port ready_i, input, 1, arready from downstream.
REQ-012 SHALL have port rdone_i, input, 1, pulse: R beat with rlast handshaked.
REQ-013 SHALL have port rdone_id_i, input, LOG_N_TARG, requester owning that R burst.
REQ-014 SHALL have port busy_o, output, N_TARG_PORT, bit i = counter i nonzero.
REQ-015 SHALL have port err_o, output, 1, sticky underflow error flag.

Function
REQ-016 SHALL implement FSM IDLE/GRANT; state, sel_o, pointer and counters registered.
REQ-017 Eligible(i) SHALL be req_i[i] and cnt[i] < MAX_OUTST.
REQ-018 In IDLE with any eligible, SHALL register winner = first eligible at or after pointer (wrapping at N_TARG_PORT-1 -> 0), go GRANT next cycle.
REQ-019 In GRANT, valid_o SHALL equal req_i[sel_o]; in IDLE valid_o SHALL be 0.
REQ-020 gnt_o SHALL be one-hot(sel_o) AND valid_o AND ready_i; all zeros otherwise.
REQ-021 Accept = valid_o and ready_i; sel_o SHALL NOT change in GRANT before accept (no re-arbitration while stalled).
REQ-022 On accept, pointer SHALL become (sel_o+1) mod N_TARG_PORT and cnt[sel_o] SHALL increment.
REQ-023 On accept, SHALL re-arbitrate in the same cycle from the new pointer using post-update counters: winner -> stay GRANT with new sel_o (back-to-back, 1 AR/cycle); none -> IDLE.
REQ-024 If req_i[sel_o] drops in GRANT without accept, SHALL return to IDLE; pointer and counters unchanged.
REQ-025 rdone_i SHALL decrement cnt[rdone_id_i]; simultaneous increment and decrement on same index SHALL leave it unchanged.
REQ-026 rdone_i with cnt[rdone_id_i]==0 or rdone_id_i >= N_TARG_PORT SHALL leave counters unchanged and set err_o until reset.
REQ-027 Counter SHALL never exceed MAX_OUTST; a requester at limit SHALL be skipped, not block others.

Reset
REQ-028 On rst_n low, asynchronously: state IDLE, pointer 0, sel_o 0, all counters 0, err_o 0; hence valid_o 0, gnt_o 0, busy_o 0.
REQ-029 Reset mid-transaction SHALL discard in-flight grant and counts; first grant after release takes >=1 cycle in IDLE.

Configuration
REQ-030 Macro AXI_AR_SCHED_OUTST_LIMIT_EN defined: counters, limit, busy_o, err_o as above.
REQ-031 Macro undefined: no counters; Eligible(i)=req_i[i]; rdone_i/rdone_id_i ignored; busy_o and err_o tied 0; arbitration and handshake unchanged.

Verification
REQ-032 req_i=7'h7F, ready_i=1 constant, rdone_i pulsed per accept -> accepts in order 0,1,...,6,0 on consecutive cycles after one IDLE cycle.
REQ-033 req_i=7'h05 granted sel 0, ready_i=0 for 5 cycles -> valid_o=1, sel_o=0, gnt_o=0 for 5 cycles; then ready_i=1 -> gnt_o=7'h01, next sel_o=2.
REQ-034 Limit enabled, MAX_OUTST=8, only req_i[3] high, no rdone -> exactly 8 accepts, busy_o[3]=1, then valid_o=0; one rdone_i with id 3 -> 9th accept.
REQ-035 cnt[2]=1, accept on 2 and rdone_i id 2 same cycle -> cnt[2] stays 1; rdone_i id 4 with cnt[4]=0 -> err_o=1 and stays 1.
REQ-036 rst_n asserted while GRANT with ready_i=0 -> same cycle valid_o=0, gnt_o=0, busy_o=0, err_o=0; after release, req_i=7'h10 -> grant sel 4.
REQ-037 Macro undefined, req_i[3] high, 20 cycles ready_i=1 -> 20 accepts, busy_o=0 throughout.

Source files
------------

// File: rtl/axi_ar_rr_scheduler.sv
// axi_ar_rr_scheduler
// Round-robin scheduler for the AR channel of an N-requester AXI crossbar.
// Picks one requester at a time, holds the selection while the downstream
// port stalls, and re-arbitrates on the accept cycle so that a stream of
// requests is served at one AR per clock.
//
// Optional feature, controlled by the macro AXI_AR_SCHED_OUTST_LIMIT_EN:
//   defined   - a per-requester outstanding-read counter is kept. A requester
//               whose counter has reached MAX_OUTST is skipped by arbitration
//               until one of its R bursts completes. busy_o shows which
//               counters are nonzero. err_o latches an unexpected rdone_i.
//   undefined - no counters are kept. Every requesting port is eligible,
//               rdone_i/rdone_id_i are ignored, and busy_o/err_o are 0.
module axi_ar_rr_scheduler #(
  parameter int N_TARG_PORT = 7,
  parameter int LOG_N_TARG  = $clog2(N_TARG_PORT),
  parameter int MAX_OUTST   = 8,
  parameter int CNT_W       = $clog2(MAX_OUTST + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_TARG_PORT-1:0] req_i,
  output logic [N_TARG_PORT-1:0] gnt_o,
  output logic [LOG_N_TARG-1:0]  sel_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  input  logic                   rdone_i,
  input  logic [LOG_N_TARG-1:0]  rdone_id_i,
  output logic [N_TARG_PORT-1:0] busy_o,
  output logic                   err_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e                 state_q;
  state_e                 state_d;
  logic [LOG_N_TARG-1:0]  sel_q;
  logic [LOG_N_TARG-1:0]  sel_d;
  logic [LOG_N_TARG-1:0]  ptr_q;
  logic [LOG_N_TARG-1:0]  ptr_d;
  logic [LOG_N_TARG-1:0]  ptr_next;
  logic                   accept;

  // elig_now uses the registered counters; elig_post uses the counters as
  // they will be after this cycle's accept/rdone updates.
  logic [N_TARG_PORT-1:0] elig_now;
  logic [N_TARG_PORT-1:0] elig_post;

  // {found, index} from the round-robin search
  logic [LOG_N_TARG:0]    pick_now;
  logic [LOG_N_TARG:0]    pick_post;

  // First eligible index at or after ptr, wrapping from N_TARG_PORT-1 to 0.
  // The loop runs from the farthest offset to the nearest one, so the
  // nearest eligible index is the last one written and therefore wins.
  function automatic logic [LOG_N_TARG:0] rr_pick(
    input logic [N_TARG_PORT-1:0] elig,
    input logic [LOG_N_TARG-1:0]  ptr
  );
    logic [LOG_N_TARG:0] res;
    int                  idx;
    res = '0;
    for (int k = N_TARG_PORT - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_TARG_PORT) begin
        idx = idx - N_TARG_PORT;
      end
      if (elig[idx]) begin
        res = {1'b1, LOG_N_TARG'(idx)};
      end
    end
    return res;
  endfunction

  assign valid_o  = (state_q == GRANT) && req_i[sel_q];
  assign accept   = valid_o && ready_i;
  assign gnt_o    = accept ? (N_TARG_PORT'(1) << sel_q) : '0;
  assign sel_o    = sel_q;
  assign ptr_next = (sel_q == LOG_N_TARG'(N_TARG_PORT - 1)) ? '0 : sel_q + 1'b1;

  assign pick_now  = rr_pick(elig_now, ptr_q);
  assign pick_post = rr_pick(elig_post, ptr_next);

  // Next-state logic: arbitrate from IDLE, hold the selection while stalled,
  // and re-arbitrate from the advanced pointer on the accept cycle.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_now[LOG_N_TARG]) begin
          state_d = GRANT;
          sel_d   = pick_now[LOG_N_TARG-1:0];
        end
      end
      GRANT: begin
        if (accept) begin
          ptr_d = ptr_next;
          if (pick_post[LOG_N_TARG]) begin
            sel_d = pick_post[LOG_N_TARG-1:0];
          end else begin
            state_d = IDLE;
          end
        end else if (!req_i[sel_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, selection and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef AXI_AR_SCHED_OUTST_LIMIT_EN

  logic [CNT_W-1:0] cnt_q [N_TARG_PORT];
  logic [CNT_W-1:0] cnt_d [N_TARG_PORT];
  logic             err_q;
  logic             err_d;
  logic             rdone_in_range;
  logic             rdone_cnt_zero;
  logic             rdone_ok;

  // Classify the completion: it is legal only when it names an existing
  // requester whose counter is nonzero. Anything else is an error.
  always_comb begin
    rdone_in_range = (int'(rdone_id_i) < N_TARG_PORT);
    rdone_cnt_zero = 1'b0;
    for (int i = 0; i < N_TARG_PORT; i++) begin
      if ((rdone_id_i == LOG_N_TARG'(i)) && (cnt_q[i] == '0)) begin
        rdone_cnt_zero = 1'b1;
      end
    end
    rdone_ok = rdone_i && rdone_in_range && !rdone_cnt_zero;
    err_d    = err_q || (rdone_i && !rdone_ok);
  end

  // Counter update: an accept and a completion on the same index cancel.
  always_comb begin
    for (int i = 0; i < N_TARG_PORT; i++) begin
      logic inc;
      logic dec;
      inc      = accept && (sel_q == LOG_N_TARG'(i)) && (cnt_q[i] < CNT_W'(MAX_OUTST));
      dec      = rdone_ok && (rdone_id_i == LOG_N_TARG'(i));
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec && !inc) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // Eligibility masks and busy flags derived from the counters.
  always_comb begin
    for (int i = 0; i < N_TARG_PORT; i++) begin
      elig_now[i]  = req_i[i] && (cnt_q[i] < CNT_W'(MAX_OUTST));
      elig_post[i] = req_i[i] && (cnt_d[i] < CNT_W'(MAX_OUTST));
      busy_o[i]    = (cnt_q[i] != '0);
    end
  end

  // Outstanding counters and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TARG_PORT; i++) begin
        cnt_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_TARG_PORT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

`else

  // Without counters every requesting port is always eligible.
  logic             unused_rdone;
  logic [CNT_W-1:0] unused_limit;

  assign elig_now     = req_i;
  assign elig_post    = req_i;
  assign busy_o       = '0;
  assign err_o        = 1'b0;
  assign unused_limit = CNT_W'(MAX_OUTST);
  assign unused_rdone = ^{rdone_i, rdone_id_i, unused_limit};

`endif

endmodule

// File: tb/tb_axi_ar_rr_scheduler.sv
// tb_axi_ar_rr_scheduler
// Directed self-checking bench for axi_ar_rr_scheduler with default
// parameters (7 requesters, MAX_OUTST 8). Limit-specific scenarios run only
// when AXI_AR_SCHED_OUTST_LIMIT_EN is defined. The no-counter scenario runs
// only when the macro is undefined.
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled
// 1 time unit later, well away from the next rising edge.
module tb_axi_ar_rr_scheduler;

  localparam int N  = 7;
  localparam int LW = 3;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_i;
  logic [N-1:0]  gnt_o;
  logic [LW-1:0] sel_o;
  logic          valid_o;
  logic          ready_i;
  logic          rdone_i;
  logic [LW-1:0] rdone_id_i;
  logic [N-1:0]  busy_o;
  logic          err_o;

  int total;
  int bad;

  axi_ar_rr_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .sel_o      (sel_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .rdone_i    (rdone_i),
    .rdone_id_i (rdone_id_i),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with all inputs idle. Returns just after release, still in IDLE.
  task automatic do_reset();
    rst_n      = 1'b0;
    req_i      = '0;
    ready_i    = 1'b0;
    rdone_i    = 1'b0;
    rdone_id_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_i = 7'h7F;
    ready_i = 1'b1;
    #1;
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_valid got=%b want=0", valid_o);
    end
    total++;
    if (gnt_o !== 7'h00) begin
      bad++;
      $display("[TB] FAIL reset_gnt got=%h want=00", gnt_o);
    end
    total++;
    if (sel_o !== 3'd0) begin
      bad++;
      $display("[TB] FAIL reset_sel got=%0d want=0", sel_o);
    end
    total++;
    if (busy_o !== 7'h00 || err_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_busy_err got=%h/%b want=00/0", busy_o, err_o);
    end
    do_reset();
  endtask

  // All requesters active with ready high: one IDLE cycle, then accepts in
  // order 0..6,0 on consecutive cycles.
  task automatic test_round_robin();
    logic [LW-1:0] exp_sel;
    do_reset();
    req_i   = 7'h7F;
    ready_i = 1'b1;
    #1;
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rr_idle_valid got=%b want=0", valid_o);
    end
    tick();
    for (int k = 0; k < 8; k++) begin
      exp_sel = LW'(k % N);
      total++;
      if (valid_o !== 1'b1 || sel_o !== exp_sel || gnt_o !== (7'h01 << exp_sel)) begin
        bad++;
        $display("[TB] FAIL rr_accept_%0d got valid=%b sel=%0d gnt=%h want valid=1 sel=%0d gnt=%h",
                 k, valid_o, sel_o, gnt_o, exp_sel, 7'h01 << exp_sel);
      end
      tick();
    end
`ifdef AXI_AR_SCHED_OUTST_LIMIT_EN
    total++;
    if (busy_o !== 7'h7F) begin
      bad++;
      $display("[TB] FAIL rr_busy got=%h want=7f", busy_o);
    end
`endif
    req_i = '0;
    #1;
  endtask

  // Downstream stall: selection frozen, no grant, then accept and move on.
  task automatic test_stall();
    do_reset();
    req_i   = 7'h05;
    ready_i = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (valid_o !== 1'b1 || sel_o !== 3'd0 || gnt_o !== 7'h00) begin
        bad++;
        $display("[TB] FAIL stall_%0d got valid=%b sel=%0d gnt=%h want valid=1 sel=0 gnt=00",
                 k, valid_o, sel_o, gnt_o);
      end
      tick();
    end
    ready_i = 1'b1;
    #1;
    total++;
    if (gnt_o !== 7'h01) begin
      bad++;
      $display("[TB] FAIL stall_release_gnt got=%h want=01", gnt_o);
    end
    tick();
    total++;
    if (sel_o !== 3'd2 || gnt_o !== 7'h04) begin
      bad++;
      $display("[TB] FAIL stall_next_sel got sel=%0d gnt=%h want sel=2 gnt=04", sel_o, gnt_o);
    end
    tick();
    total++;
    if (sel_o !== 3'd0 || gnt_o !== 7'h01) begin
      bad++;
      $display("[TB] FAIL stall_wrap_sel got sel=%0d gnt=%h want sel=0 gnt=01", sel_o, gnt_o);
    end
    req_i   = '0;
    ready_i = 1'b0;
    #1;
  endtask

  // Request withdrawn while stalled: back to IDLE, pointer still at 0.
  task automatic test_drop();
    do_reset();
    req_i   = 7'h08;
    ready_i = 1'b0;
    tick();
    total++;
    if (sel_o !== 3'd3 || valid_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL drop_grant got sel=%0d valid=%b want sel=3 valid=1", sel_o, valid_o);
    end
    req_i = '0;
    #1;
    total++;
    if (valid_o !== 1'b0 || gnt_o !== 7'h00) begin
      bad++;
      $display("[TB] FAIL drop_valid got valid=%b gnt=%h want valid=0 gnt=00", valid_o, gnt_o);
    end
    tick();
    req_i = 7'h7F;
    #1;
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL drop_idle got valid=%b want=0", valid_o);
    end
    tick();
    total++;
    if (sel_o !== 3'd0 || valid_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL drop_ptr got sel=%0d valid=%b want sel=0 valid=1", sel_o, valid_o);
    end
    req_i = '0;
    #1;
  endtask

  // Reset during a stalled grant, then a fresh grant to requester 4.
  task automatic test_reset_mid();
    do_reset();
    req_i   = 7'h04;
    ready_i = 1'b0;
    tick();
    total++;
    if (sel_o !== 3'd2 || valid_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_pre got sel=%0d valid=%b want sel=2 valid=1", sel_o, valid_o);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (valid_o !== 1'b0 || gnt_o !== 7'h00 || sel_o !== 3'd0 || busy_o !== 7'h00 || err_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_async got valid=%b gnt=%h sel=%0d busy=%h err=%b want 0/00/0/00/0",
               valid_o, gnt_o, sel_o, busy_o, err_o);
    end
    rst_n   = 1'b1;
    req_i   = 7'h10;
    ready_i = 1'b1;
    #1;
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_idle got valid=%b want=0", valid_o);
    end
    tick();
    total++;
    if (sel_o !== 3'd4 || valid_o !== 1'b1 || gnt_o !== 7'h10) begin
      bad++;
      $display("[TB] FAIL mid_regrant got sel=%0d valid=%b gnt=%h want sel=4 valid=1 gnt=10",
               sel_o, valid_o, gnt_o);
    end
    req_i   = '0;
    ready_i = 1'b0;
    #1;
  endtask

`ifdef AXI_AR_SCHED_OUTST_LIMIT_EN
  // A single requester stops after 8 accepts, resumes after one completion.
  task automatic test_limit();
    do_reset();
    req_i   = 7'h08;
    ready_i = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      total++;
      if (gnt_o !== 7'h08) begin
        bad++;
        $display("[TB] FAIL limit_accept_%0d got gnt=%h want=08", k, gnt_o);
      end
      tick();
    end
    total++;
    if (valid_o !== 1'b0 || busy_o !== 7'h08) begin
      bad++;
      $display("[TB] FAIL limit_full got valid=%b busy=%h want valid=0 busy=08", valid_o, busy_o);
    end
    tick();
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL limit_hold got valid=%b want=0", valid_o);
    end
    rdone_i    = 1'b1;
    rdone_id_i = 3'd3;
    tick();
    rdone_i = 1'b0;
    #1;
    tick();
    total++;
    if (valid_o !== 1'b1 || gnt_o !== 7'h08) begin
      bad++;
      $display("[TB] FAIL limit_ninth got valid=%b gnt=%h want valid=1 gnt=08", valid_o, gnt_o);
    end
    req_i   = '0;
    ready_i = 1'b0;
    #1;
  endtask

  // Accept and completion on the same index cancel; an underflow sets err_o.
  task automatic test_same_cycle();
    do_reset();
    req_i   = 7'h04;
    ready_i = 1'b1;
    tick();
    tick();
    rdone_i    = 1'b1;
    rdone_id_i = 3'd2;
    #1;
    total++;
    if (gnt_o !== 7'h04) begin
      bad++;
      $display("[TB] FAIL same_gnt got=%h want=04", gnt_o);
    end
    tick();
    ready_i = 1'b0;
    rdone_i = 1'b0;
    #1;
    total++;
    if (busy_o !== 7'h04 || err_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL same_keep got busy=%h err=%b want busy=04 err=0", busy_o, err_o);
    end
    rdone_i    = 1'b1;
    rdone_id_i = 3'd2;
    tick();
    rdone_i = 1'b0;
    #1;
    total++;
    if (busy_o !== 7'h00 || err_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL same_drain got busy=%h err=%b want busy=00 err=0", busy_o, err_o);
    end
    rdone_i    = 1'b1;
    rdone_id_i = 3'd4;
    tick();
    rdone_i = 1'b0;
    tick();
    tick();
    total++;
    if (err_o !== 1'b1 || busy_o !== 7'h00) begin
      bad++;
      $display("[TB] FAIL same_underflow got err=%b busy=%h want err=1 busy=00", err_o, busy_o);
    end
    req_i = '0;
    #1;
  endtask
`else
  // Without counters a lone requester is accepted every cycle indefinitely.
  task automatic test_no_limit();
    do_reset();
    req_i      = 7'h08;
    ready_i    = 1'b1;
    rdone_i    = 1'b1;
    rdone_id_i = 3'd5;
    tick();
    for (int k = 0; k < 20; k++) begin
      total++;
      if (gnt_o !== 7'h08 || busy_o !== 7'h00 || err_o !== 1'b0) begin
        bad++;
        $display("[TB] FAIL nolimit_%0d got gnt=%h busy=%h err=%b want gnt=08 busy=00 err=0",
                 k, gnt_o, busy_o, err_o);
      end
      tick();
    end
    req_i   = '0;
    ready_i = 1'b0;
    rdone_i = 1'b0;
    #1;
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    req_i = '0;
    ready_i = 1'b0;
    rdone_i = 1'b0;
    rdone_id_i = '0;
    #2;
    test_reset();
    test_round_robin();
    test_stall();
    test_drop();
    test_reset_mid();
`ifdef AXI_AR_SCHED_OUTST_LIMIT_EN
    test_limit();
    test_same_cycle();
`else
    test_no_limit();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
